wb_uart_host: RTL
=================

// Module: wb_uart_host
// PURPOSE
//  Wishbone initiator that drives the UART peripheral's register map. It polls RX fill (0x01),
//  drains RX bytes (0x11) into a valid/ready byte stream and pushes a byte stream into TX (0x12).
//  TX writes are paced by a credit from TX fill (0x02). Sits between a byte-stream client and the bus.
// PARAMETERS
//  DATA_BITS      8   byte width on client streams and in wb data LSBs
//  TX_LIMIT       7   max TX FIFO fill the host will create (credit = TX_LIMIT - fill, floor 0)
//  POLL_INTERVAL  64  poll timer reload; >=2
//  ACK_TIMEOUT    16  cycles waited for ack before abandoning a transaction
// PORTS
//  i_clk                in   1          system clock
//  i_rst_n              in   1          async active-low reset
//  wb_addr_out          out  32         transaction address
//  wb_data_out          out  32         write data {zeros, byte}
//  wb_data_in           in   32         read data, valid in ack cycle
//  wb_write_enable_out  out  1          1=write, 0=read
//  wb_strobe_out        out  1          request, exactly 1 cycle per transaction
//  wb_acknowledge_in    in   1          responder ack
//  i_tx_valid/i_tx_data in   1/DATA_BITS  byte to transmit
//  o_tx_ready           out  1          byte accepted when valid&&ready
//  o_rx_valid/o_rx_data out  1/DATA_BITS  received byte, held until taken
//  i_rx_ready           in   1          consumer accepts rx byte
//  o_bus_error          out  1          1-cycle pulse on ack timeout
// BEHAVIOUR
//  - Reset (async): all wb outputs 0, o_rx_valid/o_rx_data/o_bus_error 0, tx_credit=0, rx_count=0,
//    poll timer=0. Reset mid-transaction: strobe drops immediately, transaction abandoned.
//  - FSM IDLE -> STROBE -> WAIT -> IDLE. STROBE: wb_strobe_out=1 for exactly one cycle (responder acks
//    every strobe cycle; holding strobe would double-pop RX). WAIT: strobe 0, addr/we/data held.
//  - Ack sampled only in WAIT; ack in IDLE or STROBE ignored. Ack-> act on op, IDLE next cycle.
//  - WAIT timeout counter reaching ACK_TIMEOUT: o_bus_error pulse, go IDLE; POLL_RX/POLL_TX keep old
//    rx_count/credit; READ_RX delivers nothing and clears rx_count; WRITE_TX byte is lost.
//  - IDLE priority (one decision per IDLE cycle):
//    1 READ_RX: rx_count>0 and !o_rx_valid -> read 0x11
//    2 WRITE_TX: i_tx_valid and credit>0 -> o_tx_ready=1 (comb, IDLE only); latch byte; write 0x12
//    3 POLL_TX: i_tx_valid and credit==0 and timer==0 -> read 0x02
//    4 POLL_RX: rx_count==0 and timer==0 -> read 0x01
//    else stay IDLE. o_tx_ready=0 outside case 2.
//  - Poll timer: loads POLL_INTERVAL-1 on a poll STROBE cycle, decrements when nonzero.
//  - Ack actions: POLL_RX rx_count<=wb_data_in[7:0]; POLL_TX credit<=TX_LIMIT-fill, 0 if fill>=TX_LIMIT;
//    READ_RX o_rx_data<=wb_data_in[DATA_BITS-1:0], o_rx_valid<=1, rx_count-1 (floor 0);
//    WRITE_TX credit-1 (credit decremented at accept, never underflows).
//  - o_rx_valid clears cycle after valid&&ready; a new READ_RX waits until the slot is empty.
//  - Latency: TX accept cycle T -> strobe T+1 (addr 0x12, we=1, data={0,byte}); ack T+2 -> IDLE T+3.
//  - Read: strobe S -> ack S+1 -> o_rx_valid high S+2.
// TESTING
//  1 Reset low during WAIT -> wb_strobe_out 0 same cycle; after release, first op POLL_RX (addr 0x01).
//  2 i_tx_valid, data 0xA5, credit 0; 0x02 read returns 3 -> credit 4; one 1-cycle strobe at 0x12,
//    we=1, data 0x000000A5; credit 3.
//  3 0x01 returns 2; 0x11 returns 0x41 then 0x42; i_rx_ready low -> second 0x11 read withheld until
//    0x41 consumed; stream delivers 0x41, 0x42 in order.
//  4 No ack for a read of 0x11 -> o_bus_error pulses 16 cycles into WAIT; single strobe; rx_count 0.
//  5 Idle, 1-cycle ack on 0x01 returning 0 -> 0x01 strobes exactly POLL_INTERVAL+1 cycles apart.
//  6 rx_count=1, slot empty, i_tx_valid, credit 2 -> 0x11 read first, then 0x12 write.

Source files
------------

// File: rtl/wb_uart_host.sv
// Wishbone initiator for the UART register map: polls RX fill, drains RX data into a
// valid/ready byte stream and pushes a client byte stream into TX, paced by TX-fill credit.
module wb_uart_host #(
  parameter int DATA_BITS     = 8,
  parameter int TX_LIMIT      = 7,
  parameter int POLL_INTERVAL = 64,
  parameter int ACK_TIMEOUT   = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  output logic [31:0]          wb_addr_out,
  output logic [31:0]          wb_data_out,
  input  logic [31:0]          wb_data_in,
  output logic                 wb_write_enable_out,
  output logic                 wb_strobe_out,
  input  logic                 wb_acknowledge_in,
  input  logic                 i_tx_valid,
  input  logic [DATA_BITS-1:0] i_tx_data,
  output logic                 o_tx_ready,
  output logic                 o_rx_valid,
  output logic [DATA_BITS-1:0] o_rx_data,
  input  logic                 i_rx_ready,
  output logic                 o_bus_error
);

  localparam int CW = $clog2(TX_LIMIT + 1);
  localparam int TW = $clog2(POLL_INTERVAL);
  localparam int AW = $clog2(ACK_TIMEOUT + 1);

  localparam logic [31:0]   ADDR_RX_FILL = 32'h0000_0001;
  localparam logic [31:0]   ADDR_TX_FILL = 32'h0000_0002;
  localparam logic [31:0]   ADDR_RX_DATA = 32'h0000_0011;
  localparam logic [31:0]   ADDR_TX_DATA = 32'h0000_0012;
  localparam logic [TW-1:0] TIMER_RELOAD = TW'(POLL_INTERVAL - 1);
  localparam logic [AW-1:0] WAIT_LAST    = AW'(ACK_TIMEOUT - 1);
  localparam logic [31:0]   TX_LIMIT_W   = 32'(TX_LIMIT);

  typedef enum logic [1:0] {ST_IDLE, ST_STROBE, ST_WAIT} state_t;
  typedef enum logic [1:0] {OP_POLL_RX, OP_POLL_TX, OP_READ_RX, OP_WRITE_TX} op_t;

  state_t          state, next_state;
  op_t             op, next_op;
  logic            issue, accept, ack_done, timeout;
  logic [CW-1:0]   credit;
  logic [7:0]      rx_count;
  logic [TW-1:0]   timer;
  logic [AW-1:0]   wait_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= ST_IDLE;
      op    <= OP_POLL_RX;
    end else begin
      state <= next_state;
      op    <= next_op;
    end
  end

  // One decision per IDLE cycle, in fixed priority; ack is only honoured in WAIT.
  always_comb begin
    next_state = state;
    next_op    = op;
    issue      = 1'b0;
    accept     = 1'b0;
    ack_done   = 1'b0;
    timeout    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rx_count != 8'd0 && !o_rx_valid) begin
          issue   = 1'b1;
          next_op = OP_READ_RX;
        end else if (i_tx_valid && credit != '0) begin
          issue   = 1'b1;
          accept  = 1'b1;
          next_op = OP_WRITE_TX;
        end else if (i_tx_valid && timer == '0) begin
          issue   = 1'b1;
          next_op = OP_POLL_TX;
        end else if (rx_count == 8'd0 && timer == '0) begin
          issue   = 1'b1;
          next_op = OP_POLL_RX;
        end
        if (issue) next_state = ST_STROBE;
      end
      ST_STROBE: next_state = ST_WAIT;
      ST_WAIT: begin
        if (wb_acknowledge_in) begin
          ack_done   = 1'b1;
          next_state = ST_IDLE;
        end else if (wait_cnt == WAIT_LAST) begin
          timeout    = 1'b1;
          next_state = ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  assign o_tx_ready    = accept;
  assign wb_strobe_out = (state == ST_STROBE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wb_addr_out         <= '0;
      wb_data_out         <= '0;
      wb_write_enable_out <= 1'b0;
    end else if (issue) begin
      wb_write_enable_out <= 1'b0;
      wb_data_out         <= '0;
      case (next_op)
        OP_READ_RX: wb_addr_out <= ADDR_RX_DATA;
        OP_POLL_TX: wb_addr_out <= ADDR_TX_FILL;
        OP_WRITE_TX: begin
          wb_addr_out         <= ADDR_TX_DATA;
          wb_write_enable_out <= 1'b1;
          wb_data_out         <= {{(32-DATA_BITS){1'b0}}, i_tx_data};
        end
        default: wb_addr_out <= ADDR_RX_FILL;
      endcase
    end
  end

  // Poll timer reloads as a poll goes out on the bus, so polls are POLL_INTERVAL+1 apart.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      timer    <= '0;
      wait_cnt <= '0;
    end else begin
      if (state == ST_STROBE && (op == OP_POLL_RX || op == OP_POLL_TX))
        timer <= TIMER_RELOAD;
      else if (timer != '0)
        timer <= timer - TW'(1);
      if (state == ST_WAIT)
        wait_cnt <= wait_cnt + AW'(1);
      else
        wait_cnt <= '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      credit      <= '0;
      rx_count    <= '0;
      o_bus_error <= 1'b0;
    end else begin
      o_bus_error <= timeout;
      if (accept)
        credit <= credit - CW'(1);
      else if (ack_done && op == OP_POLL_TX)
        credit <= (wb_data_in >= TX_LIMIT_W) ? '0 : CW'(TX_LIMIT_W - wb_data_in);
      if (ack_done && op == OP_POLL_RX)
        rx_count <= wb_data_in[7:0];
      else if (ack_done && op == OP_READ_RX && rx_count != 8'd0)
        rx_count <= rx_count - 8'd1;
      else if (timeout && op == OP_READ_RX)
        rx_count <= 8'd0;
    end
  end

  // A lost RX read leaves the slot empty; the next poll re-learns the fill level.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_rx_valid <= 1'b0;
      o_rx_data  <= '0;
    end else if (ack_done && op == OP_READ_RX) begin
      o_rx_valid <= 1'b1;
      o_rx_data  <= wb_data_in[DATA_BITS-1:0];
    end else if (o_rx_valid && i_rx_ready) begin
      o_rx_valid <= 1'b0;
    end
  end

endmodule
